vector_checker: RTL and testbench

Self-checking stimulus/response stage for the team's unit testbenches. It holds a small loadable table of stimulus and expected-response pairs and plays each stimulus to the DUT with a one-cycle valid strobe. It then waits for the DUT's response, compares it, and reports pass/fail, the error count and the first failing index. The testbench top instantiates it next to the DUT, which removes hand-written `#delay` stimulus sequences; the waveform dump stays with the top.

---
 rtl/vc_pkg.sv | 24 ++
 rtl/vc_vec_mem.sv | 42 ++++
 rtl/vector_checker.sv | 135 +++++++++++++
 tb/tb_vector_checker.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/vc_pkg.sv
// ============================================================================
// Module   : vc_pkg
// Brief    : Shared state encoding and default widths for vector_checker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vc_pkg;

  localparam int C_DATA_W  = 8;
  localparam int C_ADDR_W  = 4;
  localparam int C_TIMEOUT = 15;
  localparam int C_TIMER_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/vc_vec_mem.sv
// ============================================================================
// Module   : vc_vec_mem
// Brief    : Stimulus/expected-response table, one sync write, async read.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vc_vec_mem
  import vc_pkg::*;
#(
  parameter int DATA_W = C_DATA_W,
  parameter int ADDR_W = C_ADDR_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_stim,
  input  logic [DATA_W-1:0] wr_exp,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_stim,
  output logic [DATA_W-1:0] rd_exp
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Contents deliberately survive reset so a run can be repeated without reloading.
  logic [DATA_W-1:0] r_stim_mem [DEPTH];
  logic [DATA_W-1:0] r_exp_mem  [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_stim_mem[wr_addr] <= wr_stim;
      r_exp_mem[wr_addr]  <= wr_exp;
    end
  end

  assign rd_stim = r_stim_mem[rd_addr];
  assign rd_exp  = r_exp_mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/vector_checker.sv
// ============================================================================
// Module   : vector_checker
// Brief    : Plays a stored vector table to a DUT and scores its responses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vector_checker
  import vc_pkg::*;
#(
  parameter int DATA_W  = C_DATA_W,
  parameter int ADDR_W  = C_ADDR_W,
  parameter int TIMEOUT = C_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_stim,
  input  logic [DATA_W-1:0] load_exp,
  input  logic              start,
  input  logic [ADDR_W:0]   num_vec,
  output logic              stim_valid,
  output logic [DATA_W-1:0] stim_data,
  input  logic              resp_valid,
  input  logic [DATA_W-1:0] resp_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err_idx,
  output logic              timeout_seen
);

  localparam int                   DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]      c_depth   = (ADDR_W + 1)'(DEPTH);
  localparam logic [C_TIMER_W-1:0] c_timeout = C_TIMER_W'(TIMEOUT);

  state_t                 r_state;
  logic [ADDR_W-1:0]      r_idx;
  logic [ADDR_W:0]        r_num;
  logic [C_TIMER_W-1:0]   r_timer;
  logic [DATA_W-1:0]      r_stim_hold;

  logic [DATA_W-1:0]      w_rd_stim;
  logic [DATA_W-1:0]      w_rd_exp;
  logic [C_TIMER_W-1:0]   w_timer_next;
  logic [ADDR_W:0]        w_num_sel;
  logic                   w_in_wait;
  logic                   w_timeout;
  logic                   w_fail;
  logic                   w_step;
  logic                   w_last;

  vc_vec_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (load_en && !busy),
    .wr_addr (load_addr),
    .wr_stim (load_stim),
    .wr_exp  (load_exp),
    .rd_addr (r_idx),
    .rd_stim (w_rd_stim),
    .rd_exp  (w_rd_exp)
  );

  assign w_in_wait    = (r_state == ST_WAIT);
  assign w_timer_next = r_timer + 1'b1;
  assign w_timeout    = w_in_wait && !resp_valid && (w_timer_next == c_timeout);
  assign w_fail       = w_timeout || (w_in_wait && resp_valid && (resp_data != w_rd_exp));
  assign w_step       = w_timeout || (w_in_wait && resp_valid);
  assign w_last       = ({1'b0, r_idx} == (r_num - 1'b1));
  assign w_num_sel    = (num_vec > c_depth) ? c_depth : num_vec;

  // The strobe cycle shows the table word directly; the hold register keeps it afterwards.
  assign stim_valid = (r_state == ST_DRIVE);
  assign stim_data  = stim_valid ? w_rd_stim : r_stim_hold;
  assign busy       = (r_state == ST_DRIVE) || (r_state == ST_WAIT);
  assign done       = (r_state == ST_DONE);
  assign pass       = done && (err_count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_idx         <= '0;
      r_num         <= '0;
      r_timer       <= '0;
      r_stim_hold   <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
      timeout_seen  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_num         <= w_num_sel;
            r_idx         <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
            timeout_seen  <= 1'b0;
            r_state       <= (w_num_sel == '0) ? ST_DONE : ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          r_stim_hold <= w_rd_stim;
          r_timer     <= '0;
          r_state     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_fail) begin
            if (err_count == '0) first_err_idx <= r_idx;
            if (err_count != c_depth) err_count <= err_count + 1'b1;
          end
          if (w_timeout) timeout_seen <= 1'b1;
          if (w_step) begin
            if (w_last) begin
              r_state <= ST_DONE;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= ST_DRIVE;
            end
          end else begin
            r_timer <= w_timer_next;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vector_checker.sv
// ============================================================================
// Module   : tb_vector_checker
// Brief    : Directed, table-driven checks for vector_checker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vector_checker;

  logic       clk;
  logic       rst;
  logic       load_en;
  logic [3:0] load_addr;
  logic [7:0] load_stim;
  logic [7:0] load_exp;
  logic       start;
  logic [4:0] num_vec;
  logic       stim_valid;
  logic [7:0] stim_data;
  logic       resp_valid;
  logic [7:0] resp_data;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] err_count;
  logic [3:0] first_err_idx;
  logic       timeout_seen;

  int checks = 0;
  int errors = 0;

  vector_checker dut (
    .clk           (clk),
    .rst           (rst),
    .load_en       (load_en),
    .load_addr     (load_addr),
    .load_stim     (load_stim),
    .load_exp      (load_exp),
    .start         (start),
    .num_vec       (num_vec),
    .stim_valid    (stim_valid),
    .stim_data     (stim_data),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .first_err_idx (first_err_idx),
    .timeout_seen  (timeout_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] nv;
    int         bad;     // -1 none, 16 all, else index whose exp is 0xFF
    int         silent;  // vector index the model never answers, -1 none
    int         exp_err;
    int         exp_first;
    bit         exp_pass;
    bit         exp_to;
    int         exp_cyc;
    int         exp_drv;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_stim_valid"}, 32'(stim_valid), 32'd0);
    chk({tag, "_stim_data"},  32'(stim_data), 32'd0);
    chk({tag, "_busy"},       32'(busy), 32'd0);
    chk({tag, "_done"},       32'(done), 32'd0);
    chk({tag, "_pass"},       32'(pass), 32'd0);
    chk({tag, "_err_count"},  32'(err_count), 32'd0);
    chk({tag, "_first_err"},  32'(first_err_idx), 32'd0);
    chk({tag, "_timeout"},    32'(timeout_seen), 32'd0);
  endtask

  task automatic load_table(input int bad);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      load_en   = 1'b1;
      load_addr = 4'(i);
      load_stim = 8'(i);
      load_exp  = (bad == 16 || bad == i) ? 8'hFF : 8'(i + 1);
    end
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Starts a run and acts as the DUT: answers stim+1 one cycle after each strobe.
  task automatic run_vec(input logic [4:0] nv, input int silent, input bit noise,
                         input int abort_at, output int cyc, output int drives);
    bit         pend;
    bit         aborted;
    logic [7:0] pdata;
    pend = 0; aborted = 0; pdata = 8'h00; cyc = 0; drives = 0;
    start   = 1'b1;
    num_vec = nv;
    @(negedge clk);
    start = 1'b0;
    while (!done && cyc < 200) begin
      if (cyc == abort_at) begin
        chk("busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrun_rst");
        @(negedge clk);
        rst = 1'b0;
        aborted = 1;
        break;
      end
      resp_valid = pend;
      resp_data  = pend ? 8'(pdata + 8'd1) : 8'h00;
      pend    = 0;
      load_en = 1'b0;
      if (stim_valid) begin
        if (drives != silent) begin
          pend  = 1;
          pdata = stim_data;
        end
        if (noise) begin
          resp_valid = 1'b1;
          resp_data  = 8'h5A;
        end
        drives++;
      end
      if (noise) begin
        load_en   = 1'b1;
        load_addr = 4'(cyc);
        load_stim = 8'hAA;
        load_exp  = 8'h55;
      end
      @(negedge clk);
      cyc++;
    end
    resp_valid = 1'b0;
    load_en    = 1'b0;
    if (!aborted) chk("run_reached_done", 32'(done), 32'd1);
  endtask

  task automatic chk_result(input string tag, input int e_err, input int e_first,
                            input bit e_pass, input bit e_to);
    chk({tag, "_done"},      32'(done), 32'd1);
    chk({tag, "_busy"},      32'(busy), 32'd0);
    chk({tag, "_pass"},      32'(pass), 32'(e_pass));
    chk({tag, "_err_count"}, 32'(err_count), 32'(e_err));
    chk({tag, "_first_err"}, 32'(first_err_idx), 32'(e_first));
    chk({tag, "_timeout"},   32'(timeout_seen), 32'(e_to));
  endtask

  initial begin
    int cyc;
    int drv;

    //            nv     bad silent err first pass to  cyc drv
    tbl[0] = '{5'd4,  -1, -1, 0,  0, 1'b1, 1'b0,  8, 4};
    tbl[1] = '{5'd4,   2, -1, 1,  2, 1'b0, 1'b0,  8, 4};
    tbl[2] = '{5'd4,  -1,  1, 1,  1, 1'b0, 1'b1, 22, 4};
    tbl[3] = '{5'd0,  -1, -1, 0,  0, 1'b1, 1'b0,  0, 0};
    tbl[4] = '{5'd16, -1, -1, 0,  0, 1'b1, 1'b0, 32, 16};
    tbl[5] = '{5'd16, -1, 15, 1, 15, 1'b0, 1'b1, 46, 16};
    tbl[6] = '{5'd3,   0,  2, 2,  0, 1'b0, 1'b1, 20, 3};
    tbl[7] = '{5'd1,  -1, -1, 0,  0, 1'b1, 1'b0,  2, 1};
    tbl[8] = '{5'd16, 16, -1, 16, 0, 1'b0, 1'b0, 32, 16};

    rst = 1'b1; load_en = 1'b0; load_addr = '0; load_stim = '0; load_exp = '0;
    start = 1'b0; num_vec = '0; resp_valid = 1'b0; resp_data = '0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Stray responses in IDLE must not register.
    resp_valid = 1'b1;
    resp_data  = 8'h00;
    @(negedge clk);
    resp_valid = 1'b0;
    chk("idle_resp_err_count", 32'(err_count), 32'd0);
    chk("idle_resp_done", 32'(done), 32'd0);

    for (int i = 0; i < 9; i++) begin
      load_table(tbl[i].bad);
      run_vec(tbl[i].nv, tbl[i].silent, 1'b0, -1, cyc, drv);
      chk_result($sformatf("v%0d", i), tbl[i].exp_err, tbl[i].exp_first,
                 tbl[i].exp_pass, tbl[i].exp_to);
      chk($sformatf("v%0d_cycles", i), 32'(cyc), 32'(tbl[i].exp_cyc));
      chk($sformatf("v%0d_drives", i), 32'(drv), 32'(tbl[i].exp_drv));
    end

    // Loading while in DONE leaves results alone; the new entry takes effect next run.
    load_table(2);
    run_vec(5'd4, -1, 1'b0, -1, cyc, drv);
    @(negedge clk);
    load_en = 1'b1; load_addr = 4'd2; load_stim = 8'd2; load_exp = 8'd3;
    @(negedge clk);
    load_en = 1'b0;
    repeat (2) @(negedge clk);
    chk_result("done_load", 1, 2, 1'b0, 1'b0);
    run_vec(5'd4, -1, 1'b0, -1, cyc, drv);
    chk_result("after_fix", 0, 0, 1'b1, 1'b0);

    // Responses in DRIVE and loads while busy are both ignored.
    load_table(2);
    run_vec(5'd4, -1, 1'b1, -1, cyc, drv);
    chk_result("noisy", 1, 2, 1'b0, 1'b0);
    chk("noisy_cycles", 32'(cyc), 32'd8);
    run_vec(5'd4, -1, 1'b0, -1, cyc, drv);
    chk_result("post_noise", 1, 2, 1'b0, 1'b0);

    // Reset in the WAIT of vector 3, then rerun on the retained table.
    run_vec(5'd4, -1, 1'b0, 7, cyc, drv);
    chk("after_rst_done", 32'(done), 32'd0);
    run_vec(5'd4, -1, 1'b0, -1, cyc, drv);
    chk_result("rerun", 1, 2, 1'b0, 1'b0);
    chk("rerun_cycles", 32'(cyc), 32'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
